conv_lbx_ctrl: RTL

// - Write/read sequencer driving the 4-line conv line-buffer (push/pop/sel/sof/eol) from a raster pixel stream.
// - Picks the target line round-robin; pops the filled lines to form 4-pixel columns; sets rotator select so the

---
 rtl/conv_lbx_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/conv_lbx_ctrl.sv
// Write/read sequencer for the 4-line conv line buffer: round-robin line writes, column pops, column handshake.
// Optional line-width checking is compiled in when CONV_LBX_CTRL_WIDTH_CHK_EN is defined.
package conv_pkg;
   typedef logic [7:0] pixel_t;
endpackage

module conv_lbx_ctrl #(
   parameter int W_MAX       = 4096,
   parameter int PRIME_LINES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld_i,
   output logic             in_rdy_o,
   input  conv_pkg::pixel_t in_dat_i,
   input  logic             in_sof_i,
   input  logic             in_eol_i,
   output logic [3:0]       lbx_push_o,
   output logic [3:0]       lbx_pop_o,
   output conv_pkg::pixel_t lbx_dat_o,
   output logic             lbx_sof_o,
   output logic             lbx_eol_o,
   output logic [3:0]       lbx_sel_o,
   output logic             col_vld_o,
   input  logic             col_rdy_i,
   output logic             col_sof_o,
   output logic             col_eol_o,
   output logic             err_o
);

   localparam int            CW        = $clog2(W_MAX + 1);
   localparam logic [CW-1:0] W_MAX_C   = CW'(W_MAX);
   localparam logic [1:0]    PRIME_C   = 2'(PRIME_LINES);
   localparam logic [1:0]    ST_IDLE   = 2'd0;
   localparam logic [1:0]    ST_PRIME  = 2'd1;
   localparam logic [1:0]    ST_STREAM = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    wptr_q, wptr_d;
   logic [1:0]    fill_q, fill_d;
   logic [3:0]    filled_q, filled_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sof_pend_q, sof_pend_d;
   logic          col_vld_q, col_vld_d;
   logic          col_sof_q, col_sof_d;
   logic          col_eol_q, col_eol_d;

   logic          stall, acc, sof_acc, wr_en, emit;
   logic          wmax_hit, line_end;
   logic [3:0]    wr_line;
   logic [CW-1:0] cnt_inc;

   assign stall    = col_vld_q & ~col_rdy_i;
   assign in_rdy_o = ~rst & ~stall;
   assign acc      = in_vld_i & in_rdy_o;
   assign sof_acc  = acc & in_sof_i;
   // Outside a frame only a sof pixel is written; everything else is dropped.
   assign wr_en    = acc & ((state_q != ST_IDLE) | in_sof_i);
   assign emit     = acc & (state_q == ST_STREAM) & ~in_sof_i;
   assign wr_line  = sof_acc ? 4'b0001 : wptr_q;
   assign cnt_inc  = (in_sof_i ? '0 : cnt_q) + CW'(1);
   assign wmax_hit = (cnt_inc == W_MAX_C);
   assign line_end = wr_en & (in_eol_i | wmax_hit);

   assign lbx_push_o = wr_en ? wr_line : 4'b0000;
   assign lbx_pop_o  = emit ? (filled_q & ~wptr_q) : 4'b0000;
   assign lbx_dat_o  = wr_en ? in_dat_i : '0;
   assign lbx_sof_o  = wr_en & in_sof_i;
   assign lbx_eol_o  = wr_en & in_eol_i;
   assign lbx_sel_o  = wr_line;
   assign col_vld_o  = col_vld_q;
   assign col_sof_o  = col_sof_q;
   assign col_eol_o  = col_eol_q;

   always_comb begin
      // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
      state_d    = state_q;
      wptr_d     = wptr_q;
      fill_d     = fill_q;
      filled_d   = filled_q;
      cnt_d      = cnt_q;
      sof_pend_d = sof_pend_q;
      col_vld_d  = col_vld_q;
      col_sof_d  = col_sof_q;
      col_eol_d  = col_eol_q;

      // A sof restarts the frame from any state; a sof+eol beat then completes line 1 below.
      if (sof_acc) begin
         state_d    = ST_PRIME;
         wptr_d     = 4'b0001;
         fill_d     = 2'd0;
         filled_d   = 4'b0000;
         sof_pend_d = 1'b1;
      end

      if (wr_en)
         cnt_d = line_end ? '0 : cnt_inc;

      if (line_end) begin
         filled_d = filled_d | wr_line;
         wptr_d   = {wr_line[2:0], wr_line[3]};
         if (fill_d != 2'd3)
            fill_d = fill_d + 2'd1;
         if (state_d == ST_PRIME && fill_d == PRIME_C)
            state_d = ST_STREAM;
      end

      if (emit)
         sof_pend_d = 1'b0;

      // A stalled column holds; otherwise the register follows this beat's emit.
      if (!stall) begin
         col_vld_d = emit;
         col_sof_d = emit & sof_pend_q;
         col_eol_d = emit & line_end;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= ST_IDLE;
         wptr_q     <= 4'b0001;
         fill_q     <= 2'd0;
         filled_q   <= 4'b0000;
         cnt_q      <= '0;
         sof_pend_q <= 1'b0;
         col_vld_q  <= 1'b0;
         col_sof_q  <= 1'b0;
         col_eol_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         fill_q     <= fill_d;
         filled_q   <= filled_d;
         cnt_q      <= cnt_d;
         sof_pend_q <= sof_pend_d;
         col_vld_q  <= col_vld_d;
         col_sof_q  <= col_sof_d;
         col_eol_q  <= col_eol_d;
      end
   end

`ifdef CONV_LBX_CTRL_WIDTH_CHK_EN
   logic [CW-1:0] width_q, width_d;
   logic          first_q, first_d;
   logic          err_q, err_d;

   // The first line of each frame sets the reference width; later lines compare against it.
   always_comb begin
      width_d = width_q;
      first_d = first_q;
      err_d   = err_q;
      if (sof_acc)
         first_d = 1'b1;
      if (line_end) begin
         if (first_d) begin
            width_d = cnt_inc;
            first_d = 1'b0;
         end else if (cnt_inc != width_q) begin
            err_d = 1'b1;
         end
      end
      if (wr_en & wmax_hit & ~in_eol_i)
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         width_q <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         width_q <= width_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
